// File: rtl/ysyx_22040088_hazard_ctrl.sv
// Pipeline sequencer: load-use, redirect flush, imem/dmem stalls, dmem timeout.
// Define HAZARD_CTRL_PERF_EN to add saturating stall/flush performance counters.
module ysyx_22040088_hazard_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_valid_i,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rf_waddr,
    input  logic             ex_redirect,
    input  logic             if_ack,
    input  logic             mem_req,
    input  logic             dmem_ack,
    output logic             pc_ena,
    output logic             pc_sel_redir,
    output logic             id_ena,
    output logic             id_valid,
    output logic             ex_ena,
    output logic             ex_valid,
    output logic             mem_ena,
    output logic             mem_valid,
    output logic             wb_ena,
    output logic             wb_valid,
    output logic             dmem_req,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
`endif
    output logic             err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    if (TIMEOUT < 2 || CNT_W < 1) begin : g_param_chk
        $error("hazard_ctrl: TIMEOUT must be >= 2 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        D_IDLE,
        D_WAIT,
        D_ERR
    } dstate_e;

    dstate_e       state;
    dstate_e       state_d;
    logic          run;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          dstall;
    logic          load_use;
    logic          rs1_hit;
    logic          rs2_hit;

    assign dmem_req = run & mem_req & (state != D_ERR);
    assign dstall   = dmem_req & ~dmem_ack;
    assign err      = (state == D_ERR);

    assign rs1_hit  = id_rs1_used & (id_rs1 == ex_rf_waddr);
    assign rs2_hit  = id_rs2_used & (id_rs2 == ex_rf_waddr);
    assign load_use = ex_valid_i & ex_is_load & (ex_rf_waddr != 5'd0)
                    & (rs1_hit | rs2_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run   <= 1'b0;
            state <= D_IDLE;
            cnt   <= '0;
        end else begin
            run   <= 1'b1;
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // cnt only runs inside D_WAIT, so it is zero on every entry
    always_comb begin
        state_d = state;
        cnt_d   = '0;
        unique case (state)
            D_IDLE: begin
                if (dstall) state_d = D_WAIT;
            end
            D_WAIT: begin
                if (dmem_ack)         state_d = D_IDLE;
                else if (cnt == LAST) state_d = D_ERR;
                else                  cnt_d   = cnt + 1'b1;
            end
            default: state_d = D_ERR;
        endcase
    end

    always_comb begin
        pc_ena       = 1'b0;
        pc_sel_redir = 1'b0;
        id_ena       = 1'b0;
        id_valid     = 1'b0;
        ex_ena       = 1'b0;
        ex_valid     = 1'b0;
        mem_ena      = 1'b0;
        mem_valid    = 1'b0;
        wb_ena       = 1'b0;
        wb_valid     = 1'b0;
        if (run && state != D_ERR && !dstall) begin
            id_ena    = 1'b1;
            ex_ena    = 1'b1;
            mem_ena   = 1'b1;
            mem_valid = 1'b1;
            wb_ena    = 1'b1;
            wb_valid  = 1'b1;
            if (ex_redirect) begin
                pc_ena       = 1'b1;
                pc_sel_redir = 1'b1;
            end else if (load_use) begin
                id_ena = 1'b0;
            end else if (!if_ack) begin
                ex_valid = 1'b1;
            end else begin
                pc_ena   = 1'b1;
                id_valid = 1'b1;
                ex_valid = 1'b1;
            end
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (run && !pc_ena && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (pc_sel_redir && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22040088_hazard_ctrl.sv
// Self-checking bench for ysyx_22040088_hazard_ctrl: directed scenarios
// plus randomized traffic against a rule-level reference model.
module tb_ysyx_22040088_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 2;
    localparam int SAT     = (1 << CNT_W) - 1;

    localparam logic [11:0] O_ZERO  = 12'b0000_0000_0000;
    localparam logic [11:0] O_RUN   = 12'b1011_1111_1100;
    localparam logic [11:0] O_LU    = 12'b0000_1011_1100;
    localparam logic [11:0] O_REDIR = 12'b1110_1011_1100;
    localparam logic [11:0] O_DST   = 12'b0000_0000_0010;
    localparam logic [11:0] O_ERR   = 12'b0000_0000_0001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rf_waddr;
    logic       id_rs1_used, id_rs2_used, ex_valid_i, ex_is_load;
    logic       ex_redirect, if_ack, mem_req, dmem_ack;
    logic       pc_ena, pc_sel_redir, id_ena, id_valid, ex_ena, ex_valid;
    logic       mem_ena, mem_valid, wb_ena, wb_valid, dmem_req, err;
`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    bit run_m, err_m, wait_m;
    int age_m, stall_m, flush_m;

    wire [11:0] obs = {pc_ena, pc_sel_redir, id_ena, id_valid, ex_ena, ex_valid,
                       mem_ena, mem_valid, wb_ena, wb_valid, dmem_req, err};

    always #5 clk = ~clk;

    ysyx_22040088_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid_i(ex_valid_i), .ex_is_load(ex_is_load),
        .ex_rf_waddr(ex_rf_waddr), .ex_redirect(ex_redirect),
        .if_ack(if_ack), .mem_req(mem_req), .dmem_ack(dmem_ack),
        .pc_ena(pc_ena), .pc_sel_redir(pc_sel_redir),
        .id_ena(id_ena), .id_valid(id_valid),
        .ex_ena(ex_ena), .ex_valid(ex_valid),
        .mem_ena(mem_ena), .mem_valid(mem_valid),
        .wb_ena(wb_ena), .wb_valid(wb_valid),
        .dmem_req(dmem_req),
`ifdef HAZARD_CTRL_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .err(err)
    );

    // Expected outputs straight from the priority rules
    function automatic logic [11:0] exp_out();
        logic lu;
        lu = ex_valid_i && ex_is_load && ex_rf_waddr != 5'd0 &&
             ((id_rs1_used && id_rs1 == ex_rf_waddr) ||
              (id_rs2_used && id_rs2 == ex_rf_waddr));
        if (!run_m) return O_ZERO;
        if (err_m) return O_ERR;
        if (mem_req && !dmem_ack) return O_DST;
        if (ex_redirect) return {10'b11_1010_1111, mem_req, 1'b0};
        if (lu) return {10'b00_0010_1111, mem_req, 1'b0};
        if (!if_ack) return {10'b00_1011_1111, mem_req, 1'b0};
        return {10'b10_1111_1111, mem_req, 1'b0};
    endfunction

    function automatic void model_reset();
        run_m = 0; err_m = 0; wait_m = 0;
        age_m = 0; stall_m = 0; flush_m = 0;
    endfunction

    // age_m = stalled cycles spent on the current outstanding access
    task automatic model_tick();
        logic [11:0] e;
        e = exp_out();
        if (!rst) begin
            model_reset();
            return;
        end
        if (run_m && !e[11] && stall_m < SAT) stall_m++;
        if (e[10] && flush_m < SAT) flush_m++;
        if (run_m && !err_m) begin
            if (!wait_m) begin
                if (mem_req && !dmem_ack) begin
                    wait_m = 1;
                    age_m  = 1;
                end
            end else if (dmem_ack) begin
                wait_m = 0;
            end else begin
                age_m++;
                if (age_m > TIMEOUT) err_m = 1;
            end
        end
        run_m = 1;
    endtask

    task automatic edge_tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_valid_i = 0; ex_is_load = 0; ex_rf_waddr = 0;
        ex_redirect = 0; if_ack = 1; mem_req = 0; dmem_ack = 0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b0;
        #1;
        edge_tick();
        rst = 1'b1;
        edge_tick();
    endtask

    task automatic test_reset();
        idle();
        @(negedge clk); vectors++;
        if (obs !== O_ZERO) begin
            miscompares++; $display("FAIL rst_hold: got %b want %b", obs, O_ZERO);
        end
        edge_tick();
        rst = 1'b1;
        @(negedge clk); vectors++;
        if (obs !== O_ZERO) begin
            miscompares++; $display("FAIL rst_first: got %b want %b", obs, O_ZERO);
        end
        edge_tick();
        @(negedge clk); vectors++;
        if (obs !== O_RUN) begin
            miscompares++; $display("FAIL rst_run: got %b want %b", obs, O_RUN);
        end
        edge_tick();
        mem_req = 1;
        edge_tick();
        edge_tick();
        #2 rst = 1'b0;
        #1 vectors++;
        if (obs !== O_ZERO) begin
            miscompares++; $display("FAIL rst_midwait: got %b want %b", obs, O_ZERO);
        end
        edge_tick();
        rst = 1'b1;
        @(negedge clk); vectors++;
        if (obs !== O_ZERO) begin
            miscompares++; $display("FAIL rst_rel_first: got %b want %b", obs, O_ZERO);
        end
        edge_tick();
        mem_req = 0;
        @(negedge clk); vectors++;
        if (obs !== O_RUN) begin
            miscompares++; $display("FAIL rst_rel_run: got %b want %b", obs, O_RUN);
        end
        edge_tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_valid_i = 1; ex_is_load = 1; ex_rf_waddr = 5;
        id_rs1 = 5; id_rs1_used = 1; id_rs2 = 1; id_rs2_used = 1;
        @(negedge clk); vectors++;
        if (obs !== O_LU) begin
            miscompares++; $display("FAIL lu_rs1: got %b want %b", obs, O_LU);
        end
        edge_tick();
        ex_valid_i = 0;
        @(negedge clk); vectors++;
        if (obs !== O_RUN) begin
            miscompares++; $display("FAIL lu_after: got %b want %b", obs, O_RUN);
        end
        edge_tick();
        ex_valid_i = 1; ex_rf_waddr = 0; id_rs1 = 0;
        @(negedge clk); vectors++;
        if (obs !== O_RUN) begin
            miscompares++; $display("FAIL lu_x0: got %b want %b", obs, O_RUN);
        end
        edge_tick();
        ex_rf_waddr = 7; id_rs2 = 7;
        @(negedge clk); vectors++;
        if (obs !== O_LU) begin
            miscompares++; $display("FAIL lu_rs2: got %b want %b", obs, O_LU);
        end
        edge_tick();
        id_rs2_used = 0;
        @(negedge clk); vectors++;
        if (obs !== O_RUN) begin
            miscompares++; $display("FAIL lu_unused: got %b want %b", obs, O_RUN);
        end
        edge_tick();
    endtask

    task automatic test_redirect();
        idle();
        ex_valid_i = 1; ex_is_load = 1; ex_rf_waddr = 3;
        id_rs1 = 3; id_rs1_used = 1; ex_redirect = 1; if_ack = 0;
        @(negedge clk); vectors++;
        if (obs !== O_REDIR) begin
            miscompares++; $display("FAIL redir_lu: got %b want %b", obs, O_REDIR);
        end
        edge_tick();
        idle();
        if_ack = 0;
        @(negedge clk); vectors++;
        if (obs !== 12'b0010_1111_1100) begin
            miscompares++;
            $display("FAIL istall: got %b want %b", obs, 12'b0010_1111_1100);
        end
        edge_tick();
        idle();
        ex_redirect = 1; mem_req = 1;
        @(negedge clk); vectors++;
        if (obs !== O_DST) begin
            miscompares++; $display("FAIL redir_dst: got %b want %b", obs, O_DST);
        end
        edge_tick();
        dmem_ack = 1;
        @(negedge clk); vectors++;
        if (obs !== (O_REDIR | 12'b10)) begin
            miscompares++;
            $display("FAIL redir_ack: got %b want %b", obs, O_REDIR | 12'b10);
        end
        edge_tick();
    endtask

    task automatic test_dmem();
        idle();
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); vectors++;
            if (obs !== O_DST) begin
                miscompares++; $display("FAIL dmem_stall%0d: got %b want %b", i, obs, O_DST);
            end
            edge_tick();
        end
        dmem_ack = 1;
        @(negedge clk); vectors++;
        if (obs !== (O_RUN | 12'b10)) begin
            miscompares++; $display("FAIL dmem_ack: got %b want %b", obs, O_RUN | 12'b10);
        end
        edge_tick();
        dmem_ack = 0;
        ex_valid_i = 1; ex_is_load = 1; ex_rf_waddr = 9;
        id_rs1 = 9; id_rs1_used = 1;
        @(negedge clk); vectors++;
        if (obs !== O_DST) begin
            miscompares++; $display("FAIL dmem_lu_hold: got %b want %b", obs, O_DST);
        end
        edge_tick();
        dmem_ack = 1;
        @(negedge clk); vectors++;
        if (obs !== (O_LU | 12'b10)) begin
            miscompares++; $display("FAIL dmem_lu_bub: got %b want %b", obs, O_LU | 12'b10);
        end
        edge_tick();
        idle();
        edge_tick();
    endtask

    task automatic test_random();
        logic [11:0] e;
        for (int i = 0; i < 400; i++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rf_waddr = 5'($urandom_range(0, 3));
            id_rs1_used = ($urandom_range(0, 3) != 0);
            id_rs2_used = ($urandom_range(0, 1) != 0);
            ex_valid_i  = ($urandom_range(0, 3) != 0);
            ex_is_load  = ($urandom_range(0, 1) != 0);
            ex_redirect = ($urandom_range(0, 5) == 0);
            if_ack      = ($urandom_range(0, 4) != 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            dmem_ack    = ($urandom_range(0, 9) < 7);
            @(negedge clk); vectors++;
            e = exp_out();
            if (obs !== e) begin
                miscompares++; $display("FAIL rand%0d: got %b want %b", i, obs, e);
            end
            edge_tick();
        end
        apply_reset();
    endtask

    task automatic test_timeout();
        idle();
        mem_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); vectors++;
            if (obs !== O_DST) begin
                miscompares++; $display("FAIL to_stall%0d: got %b want %b", i, obs, O_DST);
            end
            edge_tick();
        end
        @(negedge clk); vectors++;
        if (obs !== O_ERR) begin
            miscompares++; $display("FAIL to_err: got %b want %b", obs, O_ERR);
        end
        edge_tick();
        dmem_ack = 1; ex_redirect = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); vectors++;
            if (obs !== O_ERR) begin
                miscompares++; $display("FAIL to_sticky%0d: got %b want %b", i, obs, O_ERR);
            end
            edge_tick();
        end
        apply_reset();
        @(negedge clk); vectors++;
        if (obs !== O_RUN) begin
            miscompares++; $display("FAIL to_clear: got %b want %b", obs, O_RUN);
        end
        edge_tick();
    endtask

`ifdef HAZARD_CTRL_PERF_EN
    task automatic test_perf();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            ex_valid_i = 1; ex_is_load = 1; ex_rf_waddr = 4;
            id_rs2 = 4; id_rs2_used = 1;
            edge_tick();
            idle();
            edge_tick();
        end
        for (int i = 0; i < 2; i++) begin
            ex_redirect = 1;
            edge_tick();
            idle();
            edge_tick();
        end
        @(negedge clk); vectors++;
        if (perf_stall_cnt !== 2'd3 || perf_stall_cnt !== CNT_W'(stall_m)) begin
            miscompares++; $display("FAIL perf_stall: got %0d want 3", perf_stall_cnt);
        end
        vectors++;
        if (perf_flush_cnt !== 2'd2 || perf_flush_cnt !== CNT_W'(flush_m)) begin
            miscompares++; $display("FAIL perf_flush: got %0d want 2", perf_flush_cnt);
        end
        apply_reset();
        if_ack = 0;
        for (int i = 0; i < 5; i++) edge_tick();
        idle();
        @(negedge clk); vectors++;
        if (perf_stall_cnt !== 2'd3) begin
            miscompares++; $display("FAIL perf_sat: got %0d want 3", perf_stall_cnt);
        end
        edge_tick();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_redirect();
        test_dmem();
        test_random();
        test_timeout();
`ifdef HAZARD_CTRL_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
